snn_input_buffer: RTL and testbench
===================================

// Module: snn_input_buffer
// PURPOSE
//  Front-end capture stage of the Siamese NN datapath. Sits directly behind the
//  top-level input pins. Captures the 96-cycle Img/Kernel/Weight/Opt burst into
//  register files, then serves padded 6x6 convolution-window reads, kernel taps
//  and FC weights to the conv/FC core. The core may start convolving before the
//  burst ends by tracking img_cnt.
// PARAMETERS
//  DW      32  word width (IEEE-754 single)
//  N_IMG   96  image words per burst: 2 images x 3 channels x 4x4
//  N_KER   27  kernel words: 3 channels x 3x3
//  N_WGT    4  FC weight words (2x2)
// PORTS
//  clk           in   1    system clock, all flops rising edge
//  rst_n         in   1    asynchronous active-low reset
//  in_valid      in   1    burst qualifier from the pins
//  Img           in   32   image word, valid in every in_valid cycle
//  Kernel        in   32   kernel word, meaningful only in burst cycles 0..26
//  Weight        in   32   weight word, meaningful only in burst cycles 0..3
//  Opt           in   2    mode, meaningful only in burst cycle 0
//  rd_en         in   1    image read request
//  rd_img        in   1    image select, 0 or 1
//  rd_ch         in   2    channel 0..2
//  rd_row        in   3    padded row 0..5
//  rd_col        in   3    padded column 0..5
//  rd_data       out  32   padded pixel, registered, valid 1 cycle after rd_en
//  rd_vld        out  1    rd_en delayed 1 cycle
//  ker_idx       in   5    kernel tap 0..26 = ch*9 + r*3 + c
//  ker_data      out  32   combinational kernel tap; 0 if ker_idx > 26
//  wgt_flat      out  128  {w3,w2,w1,w0}
//  opt_q         out  2    captured Opt; bit0 1 = zero pad, 0 = replicate; bit1 = activation select, passed through
//  img_cnt       out  7    number of image words captured, 0..96
//  load_done     out  1    one-cycle pulse after the 96th word is captured
//  frame_release in   1    core finished; buffer may accept the next burst
//  err_ovf       out  1    sticky: in_valid seen in HOLD without frame_release
// BEHAVIOUR
//  - Reset: all outputs and storage 0; state IDLE.
//  - FSM IDLE -> LOAD: first in_valid=1 cycle. Opt is captured in that cycle
//    only, and word 0 is written in that same cycle.
//  - LOAD: on each in_valid=1 edge, write Img to img_mem[img_cnt] and increment
//    img_cnt. Kernel is written only while img_cnt < 27. Weight is written only
//    while img_cnt < 4. X inputs outside those windows never reach storage.
//  - LOAD with in_valid=0 (gap): hold all state and resume on the next in_valid.
//  - LOAD -> HOLD on the edge that captures word 95. Next cycle: img_cnt=96 and
//    load_done=1 for exactly 1 cycle.
//  - HOLD -> IDLE on frame_release=1; img_cnt clears to 0, storage is retained.
//    If frame_release=1 and in_valid=1 in the same cycle, go directly to LOAD and
//    capture word 0/Opt of the new burst (no lost cycle).
//  - in_valid=1 in HOLD without frame_release: data dropped, err_ovf set; it
//    clears only on reset.
//  - frame_release in IDLE/LOAD: ignored.
//  - Word index = rd_img*48 + rd_ch*16 + row*4 + col, in stream order.
//  - Padded read: inner r = clamp(rd_row-1, 0, 3), c = clamp(rd_col-1, 0, 3).
//    Border position (row or col = 0 or 5) with opt_q[0]=1 returns 32'h0.
//    With opt_q[0]=0 it returns the clamped (replicated) pixel.
//    rd_row/rd_col > 5 or rd_ch = 3 returns 32'h0.
//  - Reads of words not yet captured return current storage contents; ordering
//    against img_cnt is the core's responsibility. A read in the same cycle as a
//    write to that word returns the old value.
//  - rd_data/rd_vld: 1-cycle latency; rd_data holds its value when rd_en=0.
//  - Asynchronous reset mid-burst: FSM to IDLE, img_cnt=0, err_ovf=0; the next
//    in_valid starts a fresh burst.
// STRUCTURE
//  - Shared package snn_pkg: N_IMG/N_KER/N_WGT, state enum {IDLE, LOAD, HOLD},
//    IMG_STRIDE=48, CH_STRIDE=16, FP_ZERO=32'h0.
//  - One sub-module snn_pad_addr: combinational padded (img,ch,row,col) ->
//    {word_index, is_zero} mapping, reusable by the core's window generator.
//  - Storage is flop arrays: 96x32 image, 27x32 kernel, 4x32 weight.
// TESTING
//  1. Burst with Img[i]=i, Kernel[k]=100+k, Weight[w]=200+w, Opt=2 ->
//     load_done 1 cycle after the last beat; img_cnt=96; ker_data(26)=126;
//     wgt_flat={203,202,201,200}; opt_q=2.
//  2. Opt=1 (zero pad), read img1/ch2 at (0,3) -> 0; at (3,3) -> word 48+32+2*4+2=90.
//  3. Opt=0 (replicate), read img0/ch0 at (0,0) -> word 0; at (5,5) -> word 15;
//     at (6,0) -> 0.
//  4. Kernel/Weight driven X after cycles 26/3 -> no X in ker_data/wgt_flat;
//     Opt=X after cycle 0 -> opt_q unchanged.
//  5. Assert rst_n=0 at beat 40 -> img_cnt=0, no load_done. New full burst ->
//     correct contents, load_done once.
//  6. frame_release and in_valid in the same cycle -> new burst word 0 is
//     captured, img_cnt=1. in_valid in HOLD without release -> err_ovf=1 and
//     storage unchanged.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants for the Siamese NN front-end: burst geometry, strides,
// FSM state encodings and the FP zero word.
package snn_pkg;
  localparam int DW         = 32;
  localparam int N_IMG      = 96;
  localparam int N_KER      = 27;
  localparam int N_WGT      = 4;
  localparam int IMG_STRIDE = 48;
  localparam int CH_STRIDE  = 16;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/snn_input_buffer_if.sv
// Bundle of pin-side burst signals and core-side read/status signals of the
// input buffer; slave is the buffer, master is the pins/core side.
interface snn_input_buffer_if;
  import snn_pkg::*;

  logic           in_valid;
  logic [DW-1:0]  Img;
  logic [DW-1:0]  Kernel;
  logic [DW-1:0]  Weight;
  logic [1:0]     Opt;
  logic           rd_en;
  logic           rd_img;
  logic [1:0]     rd_ch;
  logic [2:0]     rd_row;
  logic [2:0]     rd_col;
  logic [DW-1:0]  rd_data;
  logic           rd_vld;
  logic [4:0]     ker_idx;
  logic [DW-1:0]  ker_data;
  logic [127:0]   wgt_flat;
  logic [1:0]     opt_q;
  logic [6:0]     img_cnt;
  logic           load_done;
  logic           frame_release;
  logic           err_ovf;

  modport slave (
    input  in_valid, Img, Kernel, Weight, Opt,
    input  rd_en, rd_img, rd_ch, rd_row, rd_col, ker_idx, frame_release,
    output rd_data, rd_vld, ker_data, wgt_flat, opt_q, img_cnt, load_done, err_ovf
  );

  modport master (
    output in_valid, Img, Kernel, Weight, Opt,
    output rd_en, rd_img, rd_ch, rd_row, rd_col, ker_idx, frame_release,
    input  rd_data, rd_vld, ker_data, wgt_flat, opt_q, img_cnt, load_done, err_ovf
  );
endinterface

// File: rtl/snn_pad_addr.sv
// Maps a padded 6x6 window coordinate to a stream word index plus a flag that
// forces the read result to zero (pad border, illegal row/col/channel).
module snn_pad_addr
  import snn_pkg::*;
(
  input  logic       img,
  input  logic [1:0] ch,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic       zero_pad,
  output logic [6:0] word_idx,
  output logic       is_zero
);

  // Padded coordinate 0..5 to inner 0..3; border rows/cols replicate the edge.
  function automatic logic [1:0] clamp_inner(input logic [2:0] p);
    logic [1:0] q;
    case (p)
      3'd0:    q = 2'd0;
      3'd1:    q = 2'd0;
      3'd2:    q = 2'd1;
      3'd3:    q = 2'd2;
      3'd4:    q = 2'd3;
      default: q = 2'd3;
    endcase
    return q;
  endfunction

  logic [1:0] r_s;
  logic [1:0] c_s;
  logic       border_s;
  logic       illegal_s;

  // Address and zero-forcing decode
  always_comb begin
    r_s       = clamp_inner(row);
    c_s       = clamp_inner(col);
    border_s  = (row == 3'd0) || (row == 3'd5) || (col == 3'd0) || (col == 3'd5);
    illegal_s = (row > 3'd5) || (col > 3'd5) || (ch == 2'd3);
    word_idx  = (img ? 7'(IMG_STRIDE) : 7'd0) + {1'b0, ch, 4'b0000}
              + {3'b000, r_s, 2'b00} + {5'b00000, c_s};
    is_zero   = illegal_s || (zero_pad && border_s);
  end

endmodule

// File: rtl/snn_input_buffer.sv
// Captures the 96-beat Img/Kernel/Weight/Opt burst into flop storage and serves
// padded window reads, kernel taps and FC weights to the conv/FC core.
module snn_input_buffer
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  snn_input_buffer_if.slave bus
);

  logic [DW-1:0] img_mem_r [0:N_IMG-1];
  logic [DW-1:0] ker_mem_r [0:N_KER-1];
  logic [DW-1:0] wgt_mem_r [0:N_WGT-1];

  logic [1:0]    state_r, state_nxt_s;
  logic [6:0]    img_cnt_r, cnt_nxt_s;
  logic [1:0]    opt_r;
  logic          load_done_r, err_ovf_r;
  logic [DW-1:0] rd_data_r;
  logic          rd_vld_r;

  logic          accept_s, opt_we_s, ovf_set_s, ker_we_s, wgt_we_s, done_s;
  logic [6:0]    wr_idx_s;
  logic [6:0]    pad_idx_s;
  logic          pad_zero_s;
  logic [DW-1:0] rd_word_s;
  logic [DW-1:0] ker_word_s;

  // Burst FSM next-state, write enables and write index
  always_comb begin
    accept_s    = 1'b0;
    opt_we_s    = 1'b0;
    ovf_set_s   = 1'b0;
    wr_idx_s    = 7'd0;
    state_nxt_s = state_r;
    cnt_nxt_s   = img_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          opt_we_s    = 1'b1;
          state_nxt_s = ST_LOAD;
          cnt_nxt_s   = 7'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          wr_idx_s    = img_cnt_r;
          cnt_nxt_s   = img_cnt_r + 7'd1;
          state_nxt_s = (img_cnt_r == 7'(N_IMG - 1)) ? ST_HOLD : ST_LOAD;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (bus.frame_release) begin
          // Release and a new first beat together start the next burst at once.
          if (bus.in_valid) begin
            accept_s    = 1'b1;
            opt_we_s    = 1'b1;
            state_nxt_s = ST_LOAD;
            cnt_nxt_s   = 7'd1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 7'd0;
          end
        end else begin
          ovf_set_s = bus.in_valid;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 7'd0;
      end
    endcase
  end

  assign ker_we_s = accept_s && (wr_idx_s < 7'(N_KER));
  assign wgt_we_s = accept_s && (wr_idx_s < 7'(N_WGT));
  assign done_s   = accept_s && (state_r == ST_LOAD) && (img_cnt_r == 7'(N_IMG - 1));

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      img_cnt_r   <= 7'd0;
      opt_r       <= 2'd0;
      load_done_r <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      img_cnt_r   <= cnt_nxt_s;
      load_done_r <= done_s;
      if (opt_we_s) opt_r <= bus.Opt;
      if (ovf_set_s) err_ovf_r <= 1'b1;
    end
  end

  // Burst storage; Kernel/Weight beats outside their windows are never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IMG; i++) img_mem_r[i] <= FP_ZERO;
      for (int i = 0; i < N_KER; i++) ker_mem_r[i] <= FP_ZERO;
      for (int i = 0; i < N_WGT; i++) wgt_mem_r[i] <= FP_ZERO;
    end else begin
      if (accept_s) img_mem_r[wr_idx_s] <= bus.Img;
      if (ker_we_s) ker_mem_r[wr_idx_s[4:0]] <= bus.Kernel;
      if (wgt_we_s) wgt_mem_r[wr_idx_s[1:0]] <= bus.Weight;
    end
  end

  snn_pad_addr u_pad_addr (
    .img      (bus.rd_img),
    .ch       (bus.rd_ch),
    .row      (bus.rd_row),
    .col      (bus.rd_col),
    .zero_pad (opt_r[0]),
    .word_idx (pad_idx_s),
    .is_zero  (pad_zero_s)
  );

  // Padded pixel and kernel tap selection
  always_comb begin
    rd_word_s  = FP_ZERO;
    ker_word_s = FP_ZERO;
    if (!pad_zero_s && (pad_idx_s < 7'(N_IMG))) begin
      rd_word_s = img_mem_r[pad_idx_s];
    end else begin
      rd_word_s = FP_ZERO;
    end
    if (bus.ker_idx < 5'(N_KER)) begin
      ker_word_s = ker_mem_r[bus.ker_idx];
    end else begin
      ker_word_s = FP_ZERO;
    end
  end

  // Registered read port; data holds while rd_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= FP_ZERO;
      rd_vld_r  <= 1'b0;
    end else begin
      rd_vld_r <= bus.rd_en;
      if (bus.rd_en) rd_data_r <= rd_word_s;
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.rd_vld    = rd_vld_r;
  assign bus.ker_data  = ker_word_s;
  assign bus.wgt_flat  = {wgt_mem_r[3], wgt_mem_r[2], wgt_mem_r[1], wgt_mem_r[0]};
  assign bus.opt_q     = opt_r;
  assign bus.img_cnt   = img_cnt_r;
  assign bus.load_done = load_done_r;
  assign bus.err_ovf   = err_ovf_r;

endmodule

// File: tb/tb_snn_input_buffer.sv
// Directed self-checking bench for snn_input_buffer: burst capture, padded
// reads in both pad modes, mid-burst reset, release/restart and overflow.
module tb_snn_input_buffer;
  import snn_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  int   done_base;

  snn_input_buffer_if bus ();

  snn_input_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (bus.load_done) done_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats; Kernel/Weight/Opt carry junk outside their windows
  task automatic burst(input logic [1:0] opt, input int base, input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        step();
        check("gap_hold_cnt", bus.img_cnt, 128'(i));
      end
      bus.in_valid = 1'b1;
      bus.Img      = 32'(base + i);
      bus.Kernel   = (i < 27) ? 32'(100 + i) : 32'hFFFF_FFFF;
      bus.Weight   = (i < 4)  ? 32'(200 + i) : 32'hFFFF_FFFF;
      bus.Opt      = (i == 0) ? opt : 2'b11;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic img, input logic [1:0] ch,
                    input logic [2:0] row, input logic [2:0] col, input logic [31:0] exp_v);
    bus.rd_en  = 1'b1;
    bus.rd_img = img;
    bus.rd_ch  = ch;
    bus.rd_row = row;
    bus.rd_col = col;
    step();
    bus.rd_en = 1'b0;
    check(tag, bus.rd_data, 128'(exp_v));
  endtask

  task automatic release_frame();
    bus.frame_release = 1'b1;
    step();
    bus.frame_release = 1'b0;
    check("release_cnt", bus.img_cnt, 128'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.Img = 32'h0; bus.Kernel = 32'h0; bus.Weight = 32'h0;
    bus.Opt = 2'b00; bus.rd_en = 1'b0; bus.rd_img = 1'b0; bus.rd_ch = 2'd0;
    bus.rd_row = 3'd0; bus.rd_col = 3'd0; bus.ker_idx = 5'd0; bus.frame_release = 1'b0;
    step();
    step();
    check("rst_cnt", bus.img_cnt, 128'd0);
    check("rst_done", bus.load_done, 128'd0);
    check("rst_rdata", bus.rd_data, 128'd0);
    check("rst_wgt", bus.wgt_flat, 128'd0);
    check("rst_ovf", bus.err_ovf, 128'd0);
    rst_n = 1'b1;
    step();

    // 1: basic burst, Opt=2
    done_base = done_cnt;
    burst(2'd2, 0, 96, -1);
    check("t1_done", bus.load_done, 128'd1);
    check("t1_cnt", bus.img_cnt, 128'd96);
    bus.ker_idx = 5'd26; #1;
    check("t1_ker26", bus.ker_data, 128'd126);
    bus.ker_idx = 5'd0; #1;
    check("t1_ker0", bus.ker_data, 128'd100);
    bus.ker_idx = 5'd27; #1;
    check("t1_ker27", bus.ker_data, 128'd0);
    check("t1_wgt", bus.wgt_flat, {32'd203, 32'd202, 32'd201, 32'd200});
    check("t1_opt", bus.opt_q, 128'd2);
    step();
    check("t1_done_pulse", bus.load_done, 128'd0);
    check("t1_done_cnt", 128'(done_cnt - done_base), 128'd1);

    // 2: zero pad
    release_frame();
    burst(2'd1, 0, 96, -1);
    check("t2_opt", bus.opt_q, 128'd1);
    rd("t2_border", 1'b1, 2'd2, 3'd0, 3'd3, 32'd0);
    rd("t2_inner", 1'b1, 2'd2, 3'd3, 3'd3, 32'd90);
    check("t2_vld", bus.rd_vld, 128'd1);
    step();
    check("t2_hold", bus.rd_data, 128'd90);
    check("t2_vld_low", bus.rd_vld, 128'd0);
    rd("t2_ch3", 1'b0, 2'd3, 3'd2, 3'd2, 32'd0);

    // 3: replicate pad, junk Opt after beat 0
    release_frame();
    burst(2'd0, 1000, 96, -1);
    check("t3_opt", bus.opt_q, 128'd0);
    rd("t3_corner00", 1'b0, 2'd0, 3'd0, 3'd0, 32'd1000);
    rd("t3_corner55", 1'b0, 2'd0, 3'd5, 3'd5, 32'd1015);
    rd("t3_row6", 1'b0, 2'd0, 3'd6, 3'd0, 32'd0);
    rd("t3_edge25", 1'b0, 2'd0, 3'd2, 3'd5, 32'd1007);

    // 5: reset mid-burst, then fresh burst with a gap
    release_frame();
    done_base = done_cnt;
    burst(2'd1, 2000, 40, -1);
    rst_n = 1'b0;
    #1;
    check("t5_cnt", bus.img_cnt, 128'd0);
    check("t5_opt", bus.opt_q, 128'd0);
    check("t5_wgt", bus.wgt_flat, 128'd0);
    check("t5_no_done", 128'(done_cnt - done_base), 128'd0);
    step();
    rst_n = 1'b1;
    done_base = done_cnt;
    burst(2'd2, 3000, 96, 50);
    check("t5_done", bus.load_done, 128'd1);
    check("t5_cnt96", bus.img_cnt, 128'd96);
    step();
    check("t5_done_cnt", 128'(done_cnt - done_base), 128'd1);
    rd("t5_img1", 1'b1, 2'd0, 3'd1, 3'd1, 32'd3048);
    rd("t5_img0ch1", 1'b0, 2'd1, 3'd4, 3'd4, 32'd3031);

    // 6: overflow in HOLD, then release with same-cycle first beat
    bus.in_valid = 1'b1; bus.Img = 32'h0000_0BAD; bus.Opt = 2'b01;
    step();
    bus.in_valid = 1'b0;
    check("t6_ovf", bus.err_ovf, 128'd1);
    check("t6_cnt", bus.img_cnt, 128'd96);
    check("t6_opt", bus.opt_q, 128'd2);
    rd("t6_unchanged", 1'b0, 2'd0, 3'd1, 3'd1, 32'd3000);
    bus.in_valid = 1'b1; bus.frame_release = 1'b1; bus.Img = 32'd4000; bus.Opt = 2'b01;
    step();
    bus.in_valid = 1'b0; bus.frame_release = 1'b0;
    check("t6_restart_cnt", bus.img_cnt, 128'd1);
    check("t6_restart_opt", bus.opt_q, 128'd1);
    check("t6_ovf_sticky", bus.err_ovf, 128'd1);
    rd("t6_word0", 1'b0, 2'd0, 3'd1, 3'd1, 32'd4000);
    rd("t6_word1", 1'b0, 2'd0, 3'd1, 3'd2, 32'd3001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
